fifo: RTL and testbench

- Single-clock circular-buffer FIFO, DEPTH words of WIDTH bits, non-power-of-2 depth supported.
- Producer side uses a 4-phase rdy/done handshake; consumer side uses a 4-phase rdy/done handshake.
- Sits between a word-serial transmitter and receiver; exposes empty/full status flags.

---
 rtl/fifo.sv | 110 +++++++++++
 tb/tb_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Circular-buffer FIFO (DEPTH x WIDTH, any depth >= 2) with 4-phase rdy/done handshakes on both sides; optional almost flags under FIFO_ALMOST_FLAGS_EN.
// Latency: tx_done one clock after tx_rdy is sampled (not full); rx_rdy one clock after the word lands in an empty FIFO.
// Backpressure: when full the producer is held in TX_IDLE with tx_done low; the consumer holds out_data until rx_done.
module fifo #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_rdy,
   output logic             tx_done,
   input  logic [WIDTH-1:0] in_data,
   output logic             rx_rdy,
   input  logic             rx_done,
   output logic [WIDTH-1:0] out_data,
   output logic             empty,
   output logic             full
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   output logic             almost_full,
   output logic             almost_empty
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_ACK} rx_state_t;

   tx_state_t        tx_state, tx_next;
   rx_state_t        rx_state, rx_next;
   logic [WIDTH-1:0] buffer [DEPTH];
   logic [PW-1:0]    front, back;
   logic [CW-1:0]    count;
   logic             incr, decr, load;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign tx_done = (tx_state == TX_WAIT);
   assign rx_rdy  = (rx_state == RX_WAIT);

`ifdef FIFO_ALMOST_FLAGS_EN
   assign almost_full  = (count >= CW'(DEPTH - 1));
   assign almost_empty = (count <= CW'(1));
`endif

   always_comb begin
      tx_next = tx_state;
      incr    = 1'b0;
      case (tx_state)
         TX_IDLE: if (tx_rdy && !full) begin
            incr    = 1'b1;
            tx_next = TX_WAIT;
         end
         TX_WAIT: if (!tx_rdy) tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   // A pop completes on the first rx_done sample; RX_ACK swallows a level-held rx_done.
   always_comb begin
      rx_next = rx_state;
      load    = 1'b0;
      decr    = 1'b0;
      case (rx_state)
         RX_IDLE: if (!empty) begin
            load    = 1'b1;
            rx_next = RX_WAIT;
         end
         RX_WAIT: if (rx_done) begin
            decr    = 1'b1;
            rx_next = RX_ACK;
         end
         RX_ACK:  if (!rx_done) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         rx_state <= RX_IDLE;
         front    <= '0;
         back     <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         tx_state <= tx_next;
         rx_state <= rx_next;
         if (incr) back <= next_ptr(back);
         if (decr) front <= next_ptr(front);
         if (load) out_data <= buffer[front];
         case ({incr, decr})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (incr) buffer[back] <= in_data;
   end

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed fill/full/drain/wrap/reset phases plus randomized traffic, scored against a queue model.
module tb_fifo;

   localparam int DEPTH = 5;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tx_rdy;
   logic             tx_done;
   logic [WIDTH-1:0] in_data;
   logic             rx_rdy;
   logic             rx_done;
   logic [WIDTH-1:0] out_data;
   logic             empty;
   logic             full;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic             almost_full;
   logic             almost_empty;
`endif

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb_q [$];
   int               mcnt = 0;

   fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_rdy   (tx_rdy),
      .tx_done  (tx_done),
      .in_data  (in_data),
      .rx_rdy   (rx_rdy),
      .rx_done  (rx_done),
      .out_data (out_data),
      .empty    (empty),
      .full     (full)
`ifdef FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out t=%0t", name, $time);
   endtask

   // Monitor: the model is a queue of accepted words plus an occupancy count.
   initial begin
      logic             prev_tx = 1'b0;
      logic             prev_rx = 1'b0;
      logic [WIDTH-1:0] held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb_q.delete();
            mcnt    = 0;
            prev_tx = 1'b0;
            prev_rx = 1'b0;
         end else begin
            if (tx_done && !prev_tx) begin
               sb_q.push_back(in_data);
               mcnt++;
            end
            if (!rx_rdy && prev_rx) mcnt--;
            if (rx_rdy && !prev_rx) begin
               if (sb_q.size() == 0) begin
                  timeout("rx_unexpected_word");
               end else begin
                  held = sb_q.pop_front();
                  chk("rx_order", int'(out_data), int'(held));
               end
            end else if (rx_rdy) begin
               chk("rx_hold", int'(out_data), int'(held));
            end
            chk("empty_flag", int'(empty), int'(mcnt == 0));
            chk("full_flag", int'(full), int'(mcnt == DEPTH));
`ifdef FIFO_ALMOST_FLAGS_EN
            chk("almost_full", int'(almost_full), int'(mcnt >= DEPTH - 1));
            chk("almost_empty", int'(almost_empty), int'(mcnt <= 1));
`endif
            prev_tx = tx_done;
            prev_rx = rx_rdy;
         end
      end
   end

   task automatic push(input logic [WIDTH-1:0] d);
      int n;
      @(posedge clk); #1;
      in_data = d;
      tx_rdy  = 1'b1;
      for (n = 0; n < 300 && !tx_done; n++) begin
         @(posedge clk); #1;
      end
      if (!tx_done) timeout("push_tx_done_rise");
      tx_rdy = 1'b0;
      for (n = 0; n < 5 && tx_done; n++) begin
         @(posedge clk); #1;
      end
      if (tx_done) timeout("push_tx_done_fall");
   endtask

   task automatic wait_rx();
      int n;
      for (n = 0; n < 300 && !rx_rdy; n++) begin
         @(posedge clk); #1;
      end
      if (!rx_rdy) timeout("wait_rx_rdy");
   endtask

   task automatic pop(input int width, input int max_gap);
      @(posedge clk); #1;
      wait_rx();
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      rx_done = 1'b1;
      repeat (width) begin
         @(posedge clk); #1;
      end
      rx_done = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] fill_words [5];
      logic [WIDTH-1:0] d;
      fill_words = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D};
      rst_n   = 1'b0;
      tx_rdy  = 1'b0;
      rx_done = 1'b0;
      in_data = '0;

      // Reset and idle
      #12;
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_tx_done", int'(tx_done), 0);
      chk("rst_rx_rdy", int'(rx_rdy), 0);
      chk("rst_out_data", int'(out_data), 0);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("rst_almost_full", int'(almost_full), 0);
      chk("rst_almost_empty", int'(almost_empty), 1);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_empty", int'(empty), 1);
      chk("idle_tx_done", int'(tx_done), 0);
      chk("idle_rx_rdy", int'(rx_rdy), 0);

      // Fill to DEPTH
      foreach (fill_words[i]) push(fill_words[i]);
      chk("fill_full", int'(full), 1);

      // Write attempt while full must be ignored
      @(posedge clk); #1;
      in_data = 8'hEE;
      tx_rdy  = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("full_no_accept", int'(tx_done), 0);
      end
      tx_rdy = 1'b0;

      // Drain with one-cycle rx_done pulses
      repeat (5) pop(1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_empty", int'(empty), 1);
      chk("drain_rx_rdy", int'(rx_rdy), 0);

      // Move pointers to 4, then leave two words: front=4, back=1
      for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
      repeat (4) pop($urandom_range(1, 3), 1);
      push(8'h41);
      push(8'h42);
      wait_rx();
      // Write and pop completing on the same edge
      @(posedge clk); #1;
      in_data = 8'h43;
      tx_rdy  = 1'b1;
      rx_done = 1'b1;
      @(posedge clk); #1;
      chk("simul_tx_done", int'(tx_done), 1);
      chk("simul_rx_rdy", int'(rx_rdy), 0);
      chk("simul_empty", int'(empty), 0);
      chk("simul_full", int'(full), 0);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("simul_almost_empty", int'(almost_empty), 0);
      chk("simul_almost_full", int'(almost_full), 0);
`endif
      tx_rdy  = 1'b0;
      rx_done = 1'b0;
      repeat (2) pop(1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("wrap_drain_empty", int'(empty), 1);

      // Randomized concurrent traffic
      fork
         begin
            repeat (40) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               d = 8'($urandom);
               push(d);
            end
         end
         begin
            repeat (40) pop($urandom_range(1, 3), 3);
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("rand_empty", int'(empty), 1);

      // Reset while in TX_WAIT and RX_WAIT
      push(8'hA5);
      wait_rx();
      @(posedge clk); #1;
      in_data = 8'h5A;
      tx_rdy  = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_tx_done", int'(tx_done), 1);
      chk("pre_rst_rx_rdy", int'(rx_rdy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_done", int'(tx_done), 0);
      chk("mid_rst_rx_rdy", int'(rx_rdy), 0);
      chk("mid_rst_out_data", int'(out_data), 0);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_full", int'(full), 0);
      tx_rdy = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      repeat (3) pop(2, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_empty", int'(empty), 1);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
